// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D-cache to L2 request scheduler.
package cache_arb_pkg;

    localparam int unsigned DEF_S_OFFSET = 5;
    localparam int unsigned DEF_S_LINE   = 8 * (2 ** DEF_S_OFFSET);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} req_id_t;
    typedef logic [DEF_S_LINE-1:0] line_t;

endpackage

// File: rtl/cache_req_scheduler_if.sv
// L1 request/response and L2 port signals of the cache request scheduler.
interface cache_req_scheduler_if #(
    parameter int unsigned S_LINE = 256
);
    logic              i_read;
    logic              i_write;
    logic [31:0]       i_address;
    logic [S_LINE-1:0] i_wdata;
    logic              i_resp;
    logic [S_LINE-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [S_LINE-1:0] d_wdata;
    logic              d_resp;
    logic [S_LINE-1:0] d_rdata;

    logic              l2_read;
    logic              l2_write;
    logic [31:0]       l2_address;
    logic [S_LINE-1:0] l2_wdata;
    logic              l2_resp;
    logic [S_LINE-1:0] l2_rdata;

    // Scheduler side
    modport slave (
        input  i_read, i_write, i_address, i_wdata,
        input  d_read, d_write, d_address, d_wdata,
        input  l2_resp, l2_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output l2_read, l2_write, l2_address, l2_wdata
    );

    // Environment side (L1 caches and L2)
    modport master (
        output i_read, i_write, i_address, i_wdata,
        output d_read, d_write, d_address, d_wdata,
        output l2_resp, l2_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  l2_read, l2_write, l2_address, l2_wdata
    );

endinterface

// File: rtl/arb_perf_cnt.sv
// Saturating event counter used for the scheduler performance statistics.
module arb_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_req_scheduler.sv
// Registered round-robin scheduler sharing one L2 port between I-cache and D-cache misses.
// Optional perf counters are built only when ARB_PERF_CNT_EN is defined.
module cache_req_scheduler
    import cache_arb_pkg::*;
#(
    parameter int unsigned S_OFFSET = DEF_S_OFFSET,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_req_scheduler_if.slave bus,
    output logic [CNT_W-1:0]     perf_i_grants,
    output logic [CNT_W-1:0]     perf_d_grants,
    output logic [CNT_W-1:0]     perf_stall
);
    localparam int unsigned S_LINE = 8 * (2 ** S_OFFSET);

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [S_LINE-1:0] wdata_q, wdata_d;

    req_id_t gnt_id;
    logic    i_pend, d_pend;
    logic    i_done, d_done;

    assign i_pend = bus.i_read | bus.i_write;
    assign d_pend = bus.d_read | bus.d_write;

    always_comb begin
        // D wins a tie unless it was served last
        gnt_id   = (d_pend && (!i_pend || !last_d_q)) ? REQ_D : REQ_I;
        state_d  = state_q;
        last_d_d = last_d_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_done   = 1'b0;
        d_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    if (gnt_id == REQ_D) begin
                        state_d = BUSY_D;
                        rd_d    = bus.d_read;
                        wr_d    = bus.d_write;
                        addr_d  = bus.d_address;
                        wdata_d = bus.d_wdata;
                    end else begin
                        state_d = BUSY_I;
                        rd_d    = bus.i_read;
                        wr_d    = bus.i_write;
                        addr_d  = bus.i_address;
                        wdata_d = bus.i_wdata;
                    end
                end
            end
            BUSY_I: begin
                if (bus.l2_resp) begin
                    i_done   = 1'b1;
                    state_d  = IDLE;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    last_d_d = 1'b0;
                end
            end
            BUSY_D: begin
                if (bus.l2_resp) begin
                    d_done   = 1'b1;
                    state_d  = IDLE;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.l2_read    = rd_q;
    assign bus.l2_write   = wr_q;
    assign bus.l2_address = addr_q;
    assign bus.l2_wdata   = wdata_q;

    // Read data is broadcast; only the granted side sees a resp strobe
    assign bus.i_resp  = i_done;
    assign bus.d_resp  = d_done;
    assign bus.i_rdata = bus.l2_rdata;
    assign bus.d_rdata = bus.l2_rdata;

`ifdef ARB_PERF_CNT_EN
    logic stall_inc;
    assign stall_inc = i_pend & d_pend & (state_q != IDLE);

    arb_perf_cnt #(.CNT_W(CNT_W)) u_cnt_i (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_done),
        .count (perf_i_grants)
    );

    arb_perf_cnt #(.CNT_W(CNT_W)) u_cnt_d (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_done),
        .count (perf_d_grants)
    );

    arb_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (perf_stall)
    );
`else
    assign perf_i_grants = '0;
    assign perf_d_grants = '0;
    assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_cache_req_scheduler.sv
// Table-driven bench for cache_req_scheduler plus reset and counter sequences.
module tb_cache_req_scheduler;

    localparam int unsigned LW = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] perf_i, perf_d, perf_s;

    int n_chk  = 0;
    int n_fail = 0;

    cache_req_scheduler_if #(.S_LINE(LW)) bus ();

    cache_req_scheduler #(.S_OFFSET(5), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .perf_i_grants (perf_i),
        .perf_d_grants (perf_d),
        .perf_stall    (perf_s)
    );

`ifdef ARB_PERF_CNT_EN
    logic       sat_inc;
    logic [1:0] sat_count;

    arb_perf_cnt #(.CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sat_inc),
        .count (sat_count)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        i_rd;
        logic        i_wr;
        logic [31:0] i_addr;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_addr;
        logic        resp;
        logic        x_rd;
        logic        x_wr;
        logic [31:0] x_addr;
        logic        x_iresp;
        logic        x_dresp;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic ir, input logic iw, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic rs, input logic xr, input logic xw,
                                input logic [31:0] xa, input logic xi, input logic xd);
        vec_t v;
        v.i_rd = ir; v.i_wr = iw; v.i_addr = ia;
        v.d_rd = dr; v.d_wr = dw; v.d_addr = da;
        v.resp = rs; v.x_rd = xr; v.x_wr = xw; v.x_addr = xa;
        v.x_iresp = xi; v.x_dresp = xd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_address = '0; bus.i_wdata = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.l2_resp = 1'b0; bus.l2_rdata = '0;
    endtask

    initial begin
        logic [LW-1:0] rdata;

        //            i_rd i_wr i_addr        d_rd d_wr d_addr        rsp  x_rd x_wr x_addr ir dr
        vecs[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0,   0, 0, 32'h0,    0, 0);
        vecs[1]  = mk(1, 0, 32'h0000_1040, 0, 0, 32'h0,         0,   0, 0, 32'h0,    0, 0);
        vecs[2]  = mk(1, 0, 32'h0000_3000, 0, 0, 32'h0,         0,   1, 0, 32'h1040, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0000_3000, 0, 0, 32'h0,         1,   1, 0, 32'h1040, 1, 0);
        vecs[4]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0,   0, 0, 32'h1040, 0, 0);
        vecs[5]  = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 0,   0, 0, 32'h1040, 0, 0);
        vecs[6]  = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 0,   0, 1, 32'h2000, 0, 0);
        vecs[7]  = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 1,   0, 1, 32'h2000, 0, 1);
        vecs[8]  = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 0,   0, 0, 32'h2000, 0, 0);
        vecs[9]  = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 1,   1, 0, 32'h1040, 1, 0);
        vecs[10] = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 0,   0, 0, 32'h1040, 0, 0);
        vecs[11] = mk(1, 0, 32'h0000_1040, 0, 1, 32'h0000_2000, 1,   0, 1, 32'h2000, 0, 1);
        vecs[12] = mk(0, 0, 32'h0,         1, 0, 32'h0000_2040, 0,   0, 0, 32'h2000, 0, 0);
        vecs[13] = mk(0, 0, 32'h0,         1, 0, 32'h0000_2040, 1,   1, 0, 32'h2040, 0, 1);
        vecs[14] = mk(0, 0, 32'h0,         1, 0, 32'h0000_2040, 0,   0, 0, 32'h2040, 0, 0);
        vecs[15] = mk(0, 0, 32'h0,         1, 0, 32'h0000_2040, 0,   1, 0, 32'h2040, 0, 0);
        vecs[16] = mk(1, 0, 32'h0000_1080, 1, 0, 32'h0000_2040, 1,   1, 0, 32'h2040, 0, 1);
        vecs[17] = mk(1, 0, 32'h0000_1080, 1, 0, 32'h0000_2040, 0,   0, 0, 32'h2040, 0, 0);
        vecs[18] = mk(1, 0, 32'h0000_1080, 1, 0, 32'h0000_2040, 1,   1, 0, 32'h1080, 1, 0);
        vecs[19] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1,   0, 0, 32'h1080, 0, 0);

        idle_inputs();
`ifdef ARB_PERF_CNT_EN
        sat_inc = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset l2_read", LW'(bus.l2_read), LW'(0));
        chk("reset l2_write", LW'(bus.l2_write), LW'(0));
        chk("reset l2_address", LW'(bus.l2_address), LW'(0));
        chk("reset l2_wdata", bus.l2_wdata, LW'(0));
        chk("reset perf_i", LW'(perf_i), LW'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            rdata = {8{32'hA5A5_0000 | 32'(i)}};
            bus.i_read    = vecs[i].i_rd;
            bus.i_write   = vecs[i].i_wr;
            bus.i_address = vecs[i].i_addr;
            bus.i_wdata   = {8{vecs[i].i_addr}};
            bus.d_read    = vecs[i].d_rd;
            bus.d_write   = vecs[i].d_wr;
            bus.d_address = vecs[i].d_addr;
            bus.d_wdata   = {8{vecs[i].d_addr}};
            bus.l2_resp   = vecs[i].resp;
            bus.l2_rdata  = rdata;
            #3;
            chk($sformatf("row%0d l2_read", i), LW'(bus.l2_read), LW'(vecs[i].x_rd));
            chk($sformatf("row%0d l2_write", i), LW'(bus.l2_write), LW'(vecs[i].x_wr));
            chk($sformatf("row%0d l2_address", i), LW'(bus.l2_address), LW'(vecs[i].x_addr));
            chk($sformatf("row%0d i_resp", i), LW'(bus.i_resp), LW'(vecs[i].x_iresp));
            chk($sformatf("row%0d d_resp", i), LW'(bus.d_resp), LW'(vecs[i].x_dresp));
            if (vecs[i].x_wr) chk($sformatf("row%0d l2_wdata", i), bus.l2_wdata,
                                  {8{vecs[i].x_addr}});
            if (vecs[i].x_iresp) chk($sformatf("row%0d i_rdata", i), bus.i_rdata, rdata);
            if (vecs[i].x_dresp) chk($sformatf("row%0d d_rdata", i), bus.d_rdata, rdata);
        end

        @(posedge clk);
        #1;
        idle_inputs();
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_grants", LW'(perf_i), LW'(3));
        chk("perf_d_grants", LW'(perf_d), LW'(4));
        chk("perf_stall", LW'(perf_s), LW'(6));
`else
        chk("perf_i_grants off", LW'(perf_i), LW'(0));
        chk("perf_d_grants off", LW'(perf_d), LW'(0));
        chk("perf_stall off", LW'(perf_s), LW'(0));
`endif

        // Asynchronous reset in the middle of a D transaction
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_2000;
        @(posedge clk);
        #1;
        bus.d_read = 1'b0;
        #1;
        chk("busy_d l2_read", LW'(bus.l2_read), LW'(1));
        rst_n       = 1'b0;
        bus.l2_resp = 1'b1;
        #1;
        chk("async rst l2_read", LW'(bus.l2_read), LW'(0));
        chk("async rst l2_address", LW'(bus.l2_address), LW'(0));
        chk("async rst d_resp", LW'(bus.d_resp), LW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("stale resp i_resp", LW'(bus.i_resp), LW'(0));
        chk("stale resp d_resp", LW'(bus.d_resp), LW'(0));
        chk("stale resp l2_read", LW'(bus.l2_read), LW'(0));
        chk("post rst perf_i", LW'(perf_i), LW'(0));
        chk("post rst perf_d", LW'(perf_d), LW'(0));
        bus.l2_resp = 1'b0;

`ifdef ARB_PERF_CNT_EN
        @(posedge clk);
        #1;
        sat_inc = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sat_inc = 1'b0;
        chk("saturating counter", LW'(sat_count), LW'(3));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
